// File: rtl/mips_ctrl_alu_unit_if.sv
// Bus between the decode stage and the control/ALU block: the instruction and
// operands going in, the control flags and the registered ALU result coming out.
interface mips_ctrl_alu_unit_if #(
  parameter int W = 32
);
  logic         en;
  logic [31:0]  inst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         regdst;
  logic         branch_eq;
  logic         branch_ne;
  logic         memread;
  logic         memwrite;
  logic         memtoreg;
  logic [1:0]   aluop;
  logic         alusrc;
  logic         regwrite;
  logic         jump;
  logic [3:0]   aluctl;
  logic [W-1:0] alurslt;
  logic         zero;

  // Decode-stage side: supplies the instruction and operands.
  modport master (
    output en, inst, a, b,
    input  regdst, branch_eq, branch_ne, memread, memwrite, memtoreg,
    input  aluop, alusrc, regwrite, jump, aluctl, alurslt, zero
  );

  // Control/ALU block side.
  modport slave (
    input  en, inst, a, b,
    output regdst, branch_eq, branch_ne, memread, memwrite, memtoreg,
    output aluop, alusrc, regwrite, jump, aluctl, alurslt, zero
  );
endinterface

// File: rtl/mips_ctrl_alu_unit.sv
// MIPS main-control decode, ALU-control decode and 32-bit ALU.
// Decode and ALU-control outputs are combinational from the instruction; the
// ALU result and its zero flag sit in the EX->MEM register (1-cycle latency).
module mips_ctrl_alu_unit #(
  parameter int W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_ctrl_alu_unit_if.slave   bus
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100,
    ALU_XOR = 4'b1101
  } alu_ctl_e;

  logic [5:0]   opcode;
  logic [5:0]   funct;
  logic [15:0]  imm;
  logic [1:0]   aluop;
  logic         alusrc;
  logic [3:0]   ctl;
  logic [W-1:0] op_b;
  logic [W-1:0] alu_out;
  logic         unused_rs_rt;

  assign opcode = bus.inst[31:26];
  assign funct  = bus.inst[5:0];
  assign imm    = bus.inst[15:0];

  // Register-number fields belong to the register file, not to this block.
  assign unused_rs_rt = ^bus.inst[25:16];

  // Main control decode from the opcode; unknown opcodes behave as a NOP.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    bus.regdst    = 1'b0;
    bus.branch_eq = 1'b0;
    bus.branch_ne = 1'b0;
    bus.memread   = 1'b0;
    bus.memwrite  = 1'b0;
    bus.memtoreg  = 1'b0;
    bus.regwrite  = 1'b0;
    bus.jump      = 1'b0;
    alusrc        = 1'b0;
    aluop         = 2'b00;
    case (opcode)
      OP_RTYPE: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
        aluop        = 2'b10;
      end
      OP_LW: begin
        bus.memread  = 1'b1;
        bus.memtoreg = 1'b1;
        alusrc       = 1'b1;
        bus.regwrite = 1'b1;
      end
      OP_SW: begin
        bus.memwrite = 1'b1;
        alusrc       = 1'b1;
      end
      OP_ADDI: begin
        alusrc       = 1'b1;
        bus.regwrite = 1'b1;
      end
      OP_BEQ: begin
        bus.branch_eq = 1'b1;
        aluop         = 2'b01;
      end
      OP_BNE: begin
        bus.branch_ne = 1'b1;
        aluop         = 2'b01;
      end
      OP_J: begin
        bus.jump = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.aluop  = aluop;
  assign bus.alusrc = alusrc;

  // ALU control: fixed add/sub for memory and branch ops, funct for R-type.
  always_comb begin
    ctl = ALU_ADD;
    case (aluop)
      2'b01: ctl = ALU_SUB;
      2'b10: begin
        case (funct)
          6'b100000: ctl = ALU_ADD;
          6'b100010: ctl = ALU_SUB;
          6'b100100: ctl = ALU_AND;
          6'b100101: ctl = ALU_OR;
          6'b100110: ctl = ALU_XOR;
          6'b100111: ctl = ALU_NOR;
          6'b101010: ctl = ALU_SLT;
          default:   ctl = ALU_ADD;
        endcase
      end
      default: ctl = ALU_ADD;
    endcase
  end

  assign bus.aluctl = ctl;

  // Immediate operand is sign-extended to the datapath width.
  assign op_b = alusrc ? {{(W-16){imm[15]}}, imm} : bus.b;

  // ALU datapath; add/sub wrap silently, slt compares as two's complement.
  always_comb begin
    alu_out = '0;
    case (ctl)
      ALU_AND: alu_out = bus.a & op_b;
      ALU_OR:  alu_out = bus.a | op_b;
      ALU_ADD: alu_out = bus.a + op_b;
      ALU_SUB: alu_out = bus.a - op_b;
      ALU_SLT: alu_out = {{(W-1){1'b0}}, ($signed(bus.a) < $signed(op_b))};
      ALU_NOR: alu_out = ~(bus.a | op_b);
      ALU_XOR: alu_out = bus.a ^ op_b;
      default: alu_out = '0;
    endcase
  end

  // EX->MEM register: capture on enable, hold otherwise, clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples values from before the edge, regardless of statement order.
    if (reset) begin
      bus.alurslt <= '0;
      bus.zero    <= 1'b0;
    end else if (bus.en) begin
      bus.alurslt <= alu_out;
      bus.zero    <= (alu_out == '0);
    end
  end

endmodule

// File: tb/tb_mips_ctrl_alu_unit.sv
// Directed bench for mips_ctrl_alu_unit: decode flags, ALU control, ALU ops,
// immediate handling, enable hold and asynchronous reset.
module tb_mips_ctrl_alu_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mips_ctrl_alu_unit_if #(.W(32)) bus ();

  mips_ctrl_alu_unit #(.W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, aluop, alusrc, regwrite, jump}
  logic [10:0] flags;
  assign flags = {bus.regdst, bus.branch_eq, bus.branch_ne, bus.memread, bus.memwrite,
                  bus.memtoreg, bus.aluop, bus.alusrc, bus.regwrite, bus.jump};

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, fn};
  endfunction

  task automatic drive(input logic [31:0] i, input logic [31:0] av, input logic [31:0] bv,
                       input logic e);
    @(negedge clk);
    bus.inst = i;
    bus.a    = av;
    bus.b    = bv;
    bus.en   = e;
    #1;
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    bus.en   = 1'b1;
    bus.inst = 32'h0022_1820;
    bus.a    = 32'd5;
    bus.b    = 32'd7;
    #1;
    checks++;
    if (bus.alurslt !== 32'd0 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: alurslt=%h zero=%b, required 0/0", bus.alurslt, bus.zero);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.alurslt !== 32'd0 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_capture: alurslt=%h zero=%b, required 0/0", bus.alurslt, bus.zero);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_r_add;
    drive(32'h0022_1820, 32'd5, 32'd7, 1'b1);
    checks++;
    if (flags !== 11'b1_0000_0_10_0_1_0 || bus.aluctl !== 4'b0010) begin
      errors++;
      $display("FAIL r_add_decode: flags=%b aluctl=%b, required 10000010010/0010", flags, bus.aluctl);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.alurslt !== 32'd12 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL r_add_result: alurslt=%h zero=%b, required 0000000c/0", bus.alurslt, bus.zero);
    end
  endtask

  task automatic test_branches;
    drive(32'h1022_0003, 32'h1234, 32'h1234, 1'b1);
    checks++;
    if (flags !== 11'b0_1000_0_01_0_0_0 || bus.aluctl !== 4'b0110) begin
      errors++;
      $display("FAIL beq_decode: flags=%b aluctl=%b, required 01000001000/0110", flags, bus.aluctl);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.alurslt !== 32'd0 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL beq_result: alurslt=%h zero=%b, required 0/1", bus.alurslt, bus.zero);
    end
    drive(32'h1422_0003, 32'd5, 32'd3, 1'b1);
    checks++;
    if (flags !== 11'b0_0100_0_01_0_0_0 || bus.aluctl !== 4'b0110) begin
      errors++;
      $display("FAIL bne_decode: flags=%b aluctl=%b, required 00100001000/0110", flags, bus.aluctl);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.alurslt !== 32'd2 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL bne_result: alurslt=%h zero=%b, required 2/0", bus.alurslt, bus.zero);
    end
  endtask

  task automatic test_immediate;
    drive(32'h2022_FFFF, 32'd0, 32'h5555_5555, 1'b1);
    checks++;
    if (flags !== 11'b0_0000_0_00_1_1_0 || bus.aluctl !== 4'b0010) begin
      errors++;
      $display("FAIL addi_decode: flags=%b aluctl=%b, required 00000000110/0010", flags, bus.aluctl);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.alurslt !== 32'hFFFF_FFFF || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL addi_sext: alurslt=%h zero=%b, required ffffffff/0", bus.alurslt, bus.zero);
    end
    drive(32'h8C22_0008, 32'h100, 32'h7777, 1'b1);
    checks++;
    if (flags !== 11'b0_0010_1_00_1_1_0) begin
      errors++;
      $display("FAIL lw_decode: flags=%b, required 00010100110", flags);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.alurslt !== 32'h108) begin
      errors++;
      $display("FAIL lw_result: alurslt=%h, required 00000108", bus.alurslt);
    end
    drive(32'hAC22_FFFC, 32'h10, 32'h9, 1'b1);
    checks++;
    if (flags !== 11'b0_0001_0_00_1_0_0) begin
      errors++;
      $display("FAIL sw_decode: flags=%b, required 00001000100", flags);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.alurslt !== 32'hC) begin
      errors++;
      $display("FAIL sw_neg_offset: alurslt=%h, required 0000000c", bus.alurslt);
    end
  endtask

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] av;
    logic [31:0] bv;
    logic [3:0]  ctl;
    logic [31:0] res;
    logic        z;
  } alu_vec_t;

  task automatic test_alu_ops;
    alu_vec_t v [10];
    v[0] = '{6'b101010, 32'hFFFF_FFFF, 32'd1,        4'b0111, 32'd1,        1'b0};
    v[1] = '{6'b101010, 32'd1,        32'hFFFF_FFFF, 4'b0111, 32'd0,        1'b1};
    v[2] = '{6'b100111, 32'd0,        32'd0,        4'b1100, 32'hFFFF_FFFF, 1'b0};
    v[3] = '{6'b100100, 32'hF0F0_FF00, 32'h0FF0_F0F0, 4'b0000, 32'h00F0_F000, 1'b0};
    v[4] = '{6'b100101, 32'hF0F0_FF00, 32'h0FF0_F0F0, 4'b0001, 32'hFFF0_FFF0, 1'b0};
    v[5] = '{6'b100110, 32'hF0F0_FF00, 32'h0FF0_F0F0, 4'b1101, 32'hFF00_0FF0, 1'b0};
    v[6] = '{6'b100010, 32'd3,        32'd5,        4'b0110, 32'hFFFF_FFFE, 1'b0};
    v[7] = '{6'b100000, 32'hFFFF_FFFF, 32'd1,        4'b0010, 32'd0,        1'b1};
    v[8] = '{6'b000000, 32'd20,       32'd22,       4'b0010, 32'd42,       1'b0};
    v[9] = '{6'b111111, 32'd1,        32'd2,        4'b0010, 32'd3,        1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(rtype(v[i].fn), v[i].av, v[i].bv, 1'b1);
      checks++;
      if (bus.aluctl !== v[i].ctl) begin
        errors++;
        $display("FAIL alu_ctl[%0d]: aluctl=%b, required %b", i, bus.aluctl, v[i].ctl);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.alurslt !== v[i].res || bus.zero !== v[i].z) begin
        errors++;
        $display("FAIL alu_result[%0d]: alurslt=%h zero=%b, required %h/%b",
                 i, bus.alurslt, bus.zero, v[i].res, v[i].z);
      end
    end
  endtask

  task automatic test_control_corners;
    drive(32'h0800_0010, 32'd0, 32'd0, 1'b0);
    checks++;
    if (flags !== 11'b0_0000_0_00_0_0_1 || bus.aluctl !== 4'b0010) begin
      errors++;
      $display("FAIL j_decode: flags=%b aluctl=%b, required 00000000001/0010", flags, bus.aluctl);
    end
    drive(32'hFC22_1820, 32'd0, 32'd0, 1'b0);
    checks++;
    if (flags !== 11'b0 || bus.aluctl !== 4'b0010) begin
      errors++;
      $display("FAIL nop_decode: flags=%b aluctl=%b, required 00000000000/0010", flags, bus.aluctl);
    end
  endtask

  task automatic test_hold;
    drive(32'h0022_1820, 32'd100, 32'd23, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (bus.alurslt !== 32'd123) begin
      errors++;
      $display("FAIL hold_load: alurslt=%h, required 0000007b", bus.alurslt);
    end
    drive(32'h0022_1822, 32'd123, 32'd123, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.alurslt !== 32'd123 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL hold_en0: alurslt=%h zero=%b, required 0000007b/0", bus.alurslt, bus.zero);
    end
    drive(32'h0022_1822, 32'd123, 32'd123, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (bus.alurslt !== 32'd0 || bus.zero !== 1'b1) begin
      errors++;
      $display("FAIL hold_resume: alurslt=%h zero=%b, required 0/1", bus.alurslt, bus.zero);
    end
  endtask

  task automatic test_async_reset;
    drive(32'h0022_1820, 32'd40, 32'd2, 1'b1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.alurslt !== 32'd0 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: alurslt=%h zero=%b, required 0/0", bus.alurslt, bus.zero);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.alurslt !== 32'd0) begin
      errors++;
      $display("FAIL reset_held: alurslt=%h, required 0", bus.alurslt);
    end
    checks++;
    if (bus.regdst !== 1'b1 || bus.aluctl !== 4'b0010) begin
      errors++;
      $display("FAIL decode_in_reset: regdst=%b aluctl=%b, required 1/0010", bus.regdst, bus.aluctl);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.alurslt !== 32'd42 || bus.zero !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_capture: alurslt=%h zero=%b, required 0000002a/0", bus.alurslt, bus.zero);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_r_add();
    test_branches();
    test_immediate();
    test_alu_ops();
    test_control_corners();
    test_hold();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
